mod_trig_gen: RTL
=================

# mod_trig_gen

Square-wave bias-modulation and step-trigger generator for the closed-loop gyro chain. It produces the signed modulation value and the one-cycle trigger that the phase ramp generator consumes on its `i_mod` and `i_trig` inputs. It also produces the ADC sample-window and demodulation-sign strobes used by the demodulator. All timing is counted in system clocks from a programmable half-period, normally the loop eigen-frequency half-period.

## Interface
- `OUTPUT_BIT`, default 16: width of the modulation output, matching the ramp generator output width.

- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset; one clock, asynchronous, active-low
- `i_en`  in  1  run enable; low forces IDLE
- `i_half_cnt`  in  32  half-period length in clocks (unsigned)
- `i_amp_h`  in  OUTPUT_BIT  signed modulation level for the HIGH half
- `i_amp_l`  in  OUTPUT_BIT  signed modulation level for the LOW half
- `i_smp_dly`  in  32  sample-window start, in clocks after the half-period start (unsigned)
- `i_smp_len`  in  32  sample-window length in clocks (unsigned)
- `o_mod`  out  OUTPUT_BIT  signed modulation value, to the ramp generator `i_mod`
- `o_trig`  out  1  one-cycle pulse on the last clock of every half-period, to the ramp generator `i_trig`
- `o_sync`  out  1  one-cycle pulse on the first clock of every full period (HIGH start)
- `o_smp_en`  out  1  sample-window strobe
- `o_smp_pol`  out  1  demodulation sign: 1 during HIGH, 0 during LOW/IDLE

## Operation
- **States:** IDLE, HIGH, LOW. A 32-bit unsigned counter `cnt` runs within each half-period.
- **Shadow registers:** `half_s`, `amph_s`, `ampl_s`, `dly_s`, `len_s`.
  - Loaded from the inputs only on the IDLE→HIGH transition and on the LOW→HIGH transition.
  - Input changes at any other time take effect at the next full-period boundary.
- **Half-period clamp:** effective half-period `H = max(half_s, 4)`. An `i_half_cnt` of 0..3 yields H = 4.
- **IDLE:**
  - `cnt` = 0; all outputs 0.
  - On `i_en` = 1: load shadows, go to HIGH with `cnt` = 0.
- **HIGH/LOW:**
  - `cnt` increments each clock.
  - When `cnt` == H−1: `cnt` → 0 and the state toggles (HIGH→LOW, LOW→HIGH with shadow reload).
- **o_mod:** `amph_s` in HIGH, `ampl_s` in LOW, 0 in IDLE. Passed through unchanged with no arithmetic.
- **o_trig:** 1 exactly when `cnt` == H−1 in HIGH or LOW. This gives two pulses per period, spaced H clocks apart.
- **o_sync:** 1 exactly when state == HIGH and `cnt` == 0.
- **o_smp_en:**
  - 1 when `dly_s` ≤ `cnt` < `dly_s` + `len_s`, in HIGH or LOW.
  - The sum is formed in 33 bits, so there is no wrap.
  - The window is implicitly truncated at H−1. `len_s` = 0 gives no strobe; `dly_s` ≥ H gives no strobe.
- **o_smp_pol:** 1 in HIGH, else 0.
- **i_en falling:**
  - Takes effect at the next edge regardless of position in the period: state → IDLE, `cnt` → 0, all outputs 0.
  - No trailing `o_trig` is issued.
- **Reset:**
  - Asynchronous assertion forces IDLE, `cnt` = 0, all shadows 0, all outputs 0. This applies mid-period as well.
  - After release, operation restarts from IDLE on the first edge with `i_en` = 1.

## Timing
- All outputs are registered and decoded from registered state/`cnt`, with no combinational input→output path.
- **Start latency:** `i_en` sampled high at edge k (state IDLE) → from edge k: HIGH, `cnt` = 0, `o_mod` = `amph_s`, `o_sync` = 1.
- **Period:** exactly 2H clocks. `o_trig` is high in the last clock of each half. `o_mod` changes on the edge that ends the `o_trig` cycle.
- **Ramp generator alignment:** the ramp generator samples `o_trig` at that same edge, so its ladder update coincides with the modulation transition.
- **Simultaneous events:**
  - Input change on the LOW→HIGH edge: the new value is captured at that edge.
  - `i_en` low on a trigger cycle: the trigger is already visible in that cycle; the next cycle is IDLE.

## Test plan
- **Basic:** H=8, amp_h=1000, amp_l=−1000, dly=2, len=3.
  - `o_mod` shows 8 clocks of 1000 then 8 clocks of −1000, repeating.
  - `o_trig` pulses at `cnt` 7 of each half.
  - `o_sync` occurs every 16 clocks.
  - `o_smp_en` is high for `cnt` 2..4 in both halves; `o_smp_pol` follows the state.
- **Mid-period update:** change to H=12, amp_h=500 during a LOW half.
  - The current period completes with old values.
  - The new values appear exactly on the next `o_sync`.
- **Clamp:** `i_half_cnt` = 0 and `i_half_cnt` = 3 → H = 4, period 8. `i_half_cnt` = 4 → identical waveform.
- **Window boundaries:**
  - H=8, dly=6, len=10 → `o_smp_en` only at `cnt` 6,7.
  - dly=8 → never.
  - len=0 → never.
  - dly=0xFFFFFFF0, len=0x20 → never, with no wrap.
- **Enable and reset mid-operation:**
  - Drop `i_en` at `cnt` 3 of HIGH → all outputs 0 the next clock, with no `o_trig`.
  - Re-enable → `o_sync` and `o_mod` = amp_h one edge later.
  - Assert `i_rst_n` low mid-LOW → outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/mod_trig_gen.sv
// Square-wave bias-modulation and step-trigger generator for the closed-loop gyro chain.
// Outputs are decoded from registered state, counter and shadow registers only.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | disabled, counter cleared, all outputs 0
// HIGH    | first half-period, o_mod = amph_s, o_smp_pol = 1
// LOW     | second half-period, o_mod = ampl_s; shadows reload on exit
module mod_trig_gen #(
    parameter int OUTPUT_BIT = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic [31:0]                  i_half_cnt,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_h,
    input  logic signed [OUTPUT_BIT-1:0] i_amp_l,
    input  logic [31:0]                  i_smp_dly,
    input  logic [31:0]                  i_smp_len,
    output logic signed [OUTPUT_BIT-1:0] o_mod,
    output logic                         o_trig,
    output logic                         o_sync,
    output logic                         o_smp_en,
    output logic                         o_smp_pol
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             half_s_q, half_s_d;
    logic signed [OUTPUT_BIT-1:0] amph_s_q, amph_s_d;
    logic signed [OUTPUT_BIT-1:0] ampl_s_q, ampl_s_d;
    logic [31:0]             dly_s_q, dly_s_d;
    logic [31:0]             len_s_q, len_s_d;

    logic [31:0]             last_cnt;
    logic                    at_end;
    logic                    running;
    logic [32:0]             win_end;
    logic                    load_shadow;

    // Half-periods shorter than 4 clocks are clamped to 4.
    assign last_cnt = (half_s_q < 32'd4) ? 32'd3 : (half_s_q - 32'd1);
    assign at_end   = (cnt_q == last_cnt);
    assign running  = (state_q != ST_IDLE);
    assign win_end  = {1'b0, dly_s_q} + {1'b0, len_s_q};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            half_s_q <= '0;
            amph_s_q <= '0;
            ampl_s_q <= '0;
            dly_s_q  <= '0;
            len_s_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_s_q <= half_s_d;
            amph_s_q <= amph_s_d;
            ampl_s_q <= ampl_s_d;
            dly_s_q  <= dly_s_d;
            len_s_q  <= len_s_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_shadow = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_en) begin
                    state_d     = ST_HIGH;
                    load_shadow = 1'b1;
                end
            end
            ST_HIGH, ST_LOW: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    cnt_d = '0;
                    if (state_q == ST_HIGH) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d     = ST_HIGH;
                        load_shadow = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        half_s_d = load_shadow ? i_half_cnt : half_s_q;
        amph_s_d = load_shadow ? i_amp_h    : amph_s_q;
        ampl_s_d = load_shadow ? i_amp_l    : ampl_s_q;
        dly_s_d  = load_shadow ? i_smp_dly  : dly_s_q;
        len_s_d  = load_shadow ? i_smp_len  : len_s_q;
    end

    always_comb begin
        o_mod     = '0;
        o_smp_pol = 1'b0;
        if (state_q == ST_HIGH) begin
            o_mod     = amph_s_q;
            o_smp_pol = 1'b1;
        end else if (state_q == ST_LOW) begin
            o_mod = ampl_s_q;
        end
    end

    assign o_trig   = running && at_end;
    assign o_sync   = (state_q == ST_HIGH) && (cnt_q == 32'd0);
    // Window end is 33 bits wide so a large delay plus length cannot wrap.
    assign o_smp_en = running && ({1'b0, cnt_q} >= {1'b0, dly_s_q}) && ({1'b0, cnt_q} < win_end);

endmodule
